// File: rtl/overlay_pkg.sv
// Shared types and geometry for the round-announcement / KO overlay path.
package overlay_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned PIX_W   = 2;
  localparam int unsigned FCNT_W  = 8;

  localparam int unsigned OVL_X0_DEF   = 288;
  localparam int unsigned OVL_Y0_DEF   = 208;
  localparam int unsigned DIGIT_W_DEF  = 64;
  localparam int unsigned DIGIT_H_DEF  = 64;
  localparam int unsigned BANNER_W_DEF = 100;
  localparam int unsigned BANNER_H_DEF = 50;

  localparam logic [PIX_W-1:0] PAL_TRANSPARENT = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CNT3  = 3'd1,
    ST_CNT2  = 3'd2,
    ST_CNT1  = 3'd3,
    ST_FIGHT = 3'd4,
    ST_PLAY  = 3'd5,
    ST_KO    = 3'd6
  } ovl_state_t;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_CD3   = 3'd1,
    SEL_CD2   = 3'd2,
    SEL_CD1   = 3'd3,
    SEL_FIGHT = 3'd4,
    SEL_KO    = 3'd5
  } ovl_sel_t;

  // Which overlay ROM a sequencer state displays.
  function automatic ovl_sel_t sel_of_state(input ovl_state_t st);
    ovl_sel_t s;
    s = SEL_NONE;
    case (st)
      ST_CNT3:  s = SEL_CD3;
      ST_CNT2:  s = SEL_CD2;
      ST_CNT1:  s = SEL_CD1;
      ST_FIGHT: s = SEL_FIGHT;
      ST_KO:    s = SEL_KO;
      default:  s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/overlay_addr_gen.sv
// Stage 1 of the overlay pixel pipeline: box test and linear ROM address.
module overlay_addr_gen
  import overlay_pkg::*;
#(
  parameter int unsigned OVL_X0   = OVL_X0_DEF,
  parameter int unsigned OVL_Y0   = OVL_Y0_DEF,
  parameter int unsigned DIGIT_W  = DIGIT_W_DEF,
  parameter int unsigned DIGIT_H  = DIGIT_H_DEF,
  parameter int unsigned BANNER_W = BANNER_W_DEF,
  parameter int unsigned BANNER_H = BANNER_H_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  ovl_sel_t           sel,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               inbox,
  output ovl_sel_t           sel_s1
);

  logic [COORD_W-1:0]   box_w;
  logic [COORD_W-1:0]   box_h;
  logic [COORD_W:0]     x_ext;
  logic [COORD_W:0]     y_ext;
  logic [COORD_W:0]     x_lo;
  logic [COORD_W:0]     y_lo;
  logic [COORD_W:0]     x_hi;
  logic [COORD_W:0]     y_hi;
  logic [COORD_W-1:0]   dx;
  logic [COORD_W-1:0]   dy;
  logic [2*COORD_W-1:0] lin;
  logic                 inbox_c;

  // Image geometry of the selected ROM; NONE yields an empty box.
  always_comb begin
    box_w = '0;
    box_h = '0;
    case (sel)
      SEL_CD3, SEL_CD2, SEL_CD1: begin
        box_w = COORD_W'(DIGIT_W);
        box_h = COORD_W'(DIGIT_H);
      end
      SEL_FIGHT, SEL_KO: begin
        box_w = COORD_W'(BANNER_W);
        box_h = COORD_W'(BANNER_H);
      end
      default: begin
        box_w = '0;
        box_h = '0;
      end
    endcase
  end

  // Box test in one extra bit so the right/bottom edge cannot wrap.
  always_comb begin
    x_ext   = {1'b0, draw_x};
    y_ext   = {1'b0, draw_y};
    x_lo    = (COORD_W+1)'(OVL_X0);
    y_lo    = (COORD_W+1)'(OVL_Y0);
    x_hi    = x_lo + {1'b0, box_w};
    y_hi    = y_lo + {1'b0, box_h};
    inbox_c = (sel != SEL_NONE) &&
              (x_ext >= x_lo) && (x_ext < x_hi) &&
              (y_ext >= y_lo) && (y_ext < y_hi);
    dx      = draw_x - COORD_W'(OVL_X0);
    dy      = draw_y - COORD_W'(OVL_Y0);
    lin     = ({{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, box_w}) +
              {{COORD_W{1'b0}}, dx};
  end

  // Stage-1 register: address, in-box flag and the selection it belongs to.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rom_addr <= '0;
      inbox    <= 1'b0;
      sel_s1   <= SEL_NONE;
    end else begin
      rom_addr <= inbox_c ? ADDR_W'(lin) : '0;
      inbox    <= inbox_c;
      sel_s1   <= sel;
    end
  end

endmodule

// File: rtl/round_overlay_sequencer.sv
// Round countdown / FIGHT / KO overlay sequencer with 2-cycle pixel pipeline.
module round_overlay_sequencer
  import overlay_pkg::*;
#(
  parameter int unsigned FRAMES_DIGIT = 60,
  parameter int unsigned FRAMES_FIGHT = 60,
  parameter int unsigned FRAMES_KO    = 180,
  parameter int unsigned OVL_X0       = OVL_X0_DEF,
  parameter int unsigned OVL_Y0       = OVL_Y0_DEF,
  parameter int unsigned DIGIT_W      = DIGIT_W_DEF,
  parameter int unsigned DIGIT_H      = DIGIT_H_DEF,
  parameter int unsigned BANNER_W     = BANNER_W_DEF,
  parameter int unsigned BANNER_H     = BANNER_H_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               ko,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   q_cd3,
  input  logic [PIX_W-1:0]   q_cd2,
  input  logic [PIX_W-1:0]   q_cd1,
  input  logic [PIX_W-1:0]   q_fight,
  input  logic [PIX_W-1:0]   q_ko,
  output logic               ovl_valid,
  output logic [PIX_W-1:0]   ovl_color,
  output logic               fight_enable,
  output logic               busy,
  output logic               done
);

  ovl_state_t          state;
  ovl_state_t          state_next;
  logic [FCNT_W-1:0]   cnt;
  logic [FCNT_W-1:0]   cnt_next;
  logic [FCNT_W-1:0]   limit_m1;
  logic                counting;
  logic                expire;
  logic                done_next;
  ovl_sel_t            sel_c;
  logic                inbox_s1;
  ovl_sel_t            sel_s1;
  logic                inbox_d2;
  ovl_sel_t            sel_d2;
  logic [PIX_W-1:0]    q_sel;

  // State and frame-counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state, frame counting and the KO-complete pulse.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    limit_m1   = '0;
    counting   = 1'b0;
    case (state)
      ST_CNT3, ST_CNT2, ST_CNT1: begin
        limit_m1 = FCNT_W'(FRAMES_DIGIT - 1);
        counting = 1'b1;
      end
      ST_FIGHT: begin
        limit_m1 = FCNT_W'(FRAMES_FIGHT - 1);
        counting = 1'b1;
      end
      ST_KO: begin
        limit_m1 = FCNT_W'(FRAMES_KO - 1);
        counting = 1'b1;
      end
      default: begin
        limit_m1 = '0;
        counting = 1'b0;
      end
    endcase
    expire = counting && frame_tick && (cnt == limit_m1);

    case (state)
      ST_IDLE:  if (start)  state_next = ST_CNT3;
      ST_CNT3:  if (expire) state_next = ST_CNT2;
      ST_CNT2:  if (expire) state_next = ST_CNT1;
      ST_CNT1:  if (expire) state_next = ST_FIGHT;
      ST_FIGHT: begin
        if (ko)          state_next = ST_KO;
        else if (expire) state_next = ST_PLAY;
      end
      ST_PLAY:  if (ko)     state_next = ST_KO;
      ST_KO: begin
        if (expire) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default:  state_next = ST_IDLE;
    endcase

    // A tick that coincides with entering a state is not counted there.
    if (state_next != state)
      cnt_next = '0;
    else if (counting && frame_tick)
      cnt_next = cnt + FCNT_W'(1);
  end

  // Registered control outputs, one cycle behind the state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fight_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      fight_enable <= (state == ST_FIGHT) || (state == ST_PLAY);
      busy         <= (state != ST_IDLE);
      done         <= done_next;
    end
  end

  // ROM selection for the pixel currently presented.
  always_comb begin
    sel_c = sel_of_state(state);
  end

  overlay_addr_gen #(
    .OVL_X0   (OVL_X0),
    .OVL_Y0   (OVL_Y0),
    .DIGIT_W  (DIGIT_W),
    .DIGIT_H  (DIGIT_H),
    .BANNER_W (BANNER_W),
    .BANNER_H (BANNER_H)
  ) u_addr_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .draw_x   (draw_x),
    .draw_y   (draw_y),
    .sel      (sel_c),
    .rom_addr (rom_addr),
    .inbox    (inbox_s1),
    .sel_s1   (sel_s1)
  );

  // Stage 2: carry in-box and selection alongside the registered ROM data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inbox_d2 <= 1'b0;
      sel_d2   <= SEL_NONE;
    end else begin
      inbox_d2 <= inbox_s1;
      sel_d2   <= sel_s1;
    end
  end

  // Mux the ROM that owns this pixel; palette 0 is see-through.
  always_comb begin
    q_sel = PAL_TRANSPARENT;
    case (sel_d2)
      SEL_CD3:   q_sel = q_cd3;
      SEL_CD2:   q_sel = q_cd2;
      SEL_CD1:   q_sel = q_cd1;
      SEL_FIGHT: q_sel = q_fight;
      SEL_KO:    q_sel = q_ko;
      default:   q_sel = PAL_TRANSPARENT;
    endcase
    ovl_color = q_sel;
    ovl_valid = inbox_d2 && (sel_d2 != SEL_NONE) && (q_sel != PAL_TRANSPARENT);
  end

endmodule

// File: tb/tb_round_overlay_sequencer.sv
// Scoreboard bench for round_overlay_sequencer.
module tb_round_overlay_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        ko;
  logic        frame_tick;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [12:0] rom_addr;
  logic [1:0]  q_cd3, q_cd2, q_cd1, q_fight, q_ko;
  logic        ovl_valid;
  logic [1:0]  ovl_color;
  logic        fight_enable;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Bench state codes
  localparam int S_IDLE = 0, S_CNT3 = 1, S_CNT2 = 2, S_CNT1 = 3,
                 S_FIGHT = 4, S_PLAY = 5, S_KO = 6;
  // Probe palette values per ROM
  localparam logic [1:0] P_CD3 = 2'd1, P_CD2 = 2'd2, P_CD1 = 2'd3,
                         P_FIGHT = 2'd1, P_KO = 2'd2;

  typedef struct {
    string       tag;
    logic [12:0] addr;
    logic        valid;
    logic [1:0]  color;
  } exp_t;

  exp_t sb_q[$];

  round_overlay_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .ko           (ko),
    .frame_tick   (frame_tick),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .rom_addr     (rom_addr),
    .q_cd3        (q_cd3),
    .q_cd2        (q_cd2),
    .q_cd1        (q_cd1),
    .q_fight      (q_fight),
    .q_ko         (q_ko),
    .ovl_valid    (ovl_valid),
    .ovl_color    (ovl_color),
    .fight_enable (fight_enable),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
    end
  endtask

  // geo: 0 none, 1 digit 64x64, 2 banner 100x50, box at (288,208)
  function automatic exp_t model(input int geo, input int x, input int y, input logic [1:0] q);
    exp_t e;
    int w, h, a;
    bit in;
    w = (geo == 1) ? 64 : (geo == 2) ? 100 : 0;
    h = (geo == 1) ? 64 : (geo == 2) ? 50 : 0;
    in = (geo != 0) && (x >= 288) && (x < 288 + w) && (y >= 208) && (y < 208 + h);
    a = in ? (((y - 208) * w + (x - 288)) & 32'h1FFF) : 0;
    e.tag   = "";
    e.addr  = a[12:0];
    e.color = (geo != 0) ? q : 2'd0;
    e.valid = in && (q != 2'd0);
    return e;
  endfunction

  function automatic int st_geo(input int st);
    case (st)
      S_CNT3, S_CNT2, S_CNT1: return 1;
      S_FIGHT, S_KO:          return 2;
      default:                return 0;
    endcase
  endfunction

  function automatic logic [1:0] st_q(input int st);
    case (st)
      S_CNT3:  return P_CD3;
      S_CNT2:  return P_CD2;
      S_CNT1:  return P_CD1;
      S_FIGHT: return P_FIGHT;
      S_KO:    return P_KO;
      default: return 2'd0;
    endcase
  endfunction

  // Drive one pixel; expectation queued now, compared as the pipeline delivers it.
  task automatic pixel(input string tag, input int geo, input int x, input int y, input logic [1:0] q);
    exp_t e;
    e = model(geo, x, y, q);
    e.tag = tag;
    sb_q.push_back(e);
    draw_x = 10'(x);
    draw_y = 10'(y);
    step(1);
    draw_x = 10'd0;
    draw_y = 10'd0;
    check({tag, "_addr"}, 32'(rom_addr), 32'(sb_q[0].addr));
    step(1);
    e = sb_q.pop_front();
    check({e.tag, "_valid"}, 32'(ovl_valid), 32'(e.valid));
    check({e.tag, "_color"}, 32'(ovl_color), 32'(e.color));
  endtask

  // Identify the active overlay from two probe pixels (digit-only, banner-only).
  task automatic probe(input string tag, input int st);
    exp_t ea, eb;
    logic [5:0] got, exp;
    ea = model(st_geo(st), 300, 265, st_q(st));
    eb = model(st_geo(st), 370, 220, st_q(st));
    sb_q.push_back(ea);
    sb_q.push_back(eb);
    draw_x = 10'd300; draw_y = 10'd265;
    step(1);
    draw_x = 10'd370; draw_y = 10'd220;
    step(1);
    draw_x = 10'd0; draw_y = 10'd0;
    got[5:3] = {ovl_valid, ovl_color};
    step(1);
    got[2:0] = {ovl_valid, ovl_color};
    ea = sb_q.pop_front();
    eb = sb_q.pop_front();
    exp = {ea.valid, ea.color, eb.valid, eb.color};
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_ko();
    ko = 1'b1;
    step(1);
    ko = 1'b0;
  endtask

  int d0;

  initial begin
    reset_n    = 1'b0;
    start      = 1'b1;
    ko         = 1'b0;
    frame_tick = 1'b0;
    draw_x     = 10'd0;
    draw_y     = 10'd0;
    q_cd3 = P_CD3; q_cd2 = P_CD2; q_cd1 = P_CD1; q_fight = P_FIGHT; q_ko = P_KO;
    step(3);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_ovl_valid", 32'(ovl_valid), 32'd0);
    check("rst_ovl_color", 32'(ovl_color), 32'd0);
    check("rst_fight_enable", 32'(fight_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    start   = 1'b0;
    reset_n = 1'b1;
    step(2);
    ticks(3);
    probe("idle_no_start", S_IDLE);
    check("idle_busy", 32'(busy), 32'd0);

    pulse_start();
    step(1);
    check("cnt3_busy", 32'(busy), 32'd1);
    check("cnt3_fight_enable", 32'(fight_enable), 32'd0);

    q_cd3 = 2'd2;
    pixel("cd3_in", 1, 290, 210, 2'd2);
    q_cd3 = 2'd0;
    pixel("cd3_transparent", 1, 290, 210, 2'd0);
    q_cd3 = 2'd2;
    pixel("cd3_oob_x", 1, 352, 210, 2'd2);
    pixel("cd3_last", 1, 351, 271, 2'd2);
    q_cd3 = P_CD3;

    ticks(59);
    probe("cnt3_at_59", S_CNT3);
    ticks(1);
    probe("cnt2_at_60", S_CNT2);
    pulse_ko();
    probe("ko_in_cnt2_ignored", S_CNT2);
    ticks(59);
    probe("cnt2_at_119", S_CNT2);
    ticks(1);
    probe("cnt1_at_120", S_CNT1);
    ticks(59);
    probe("cnt1_at_179", S_CNT1);
    check("fe_before_180", 32'(fight_enable), 32'd0);
    ticks(1);
    check("fe_at_180", 32'(fight_enable), 32'd1);
    probe("fight_at_180", S_FIGHT);

    pixel("fight_corner", 2, 387, 257, P_FIGHT);
    pixel("fight_oob_x", 2, 388, 257, P_FIGHT);
    pixel("fight_oob_y", 2, 300, 258, P_FIGHT);

    ticks(59);
    probe("fight_at_239", S_FIGHT);
    ticks(1);
    probe("play_at_240", S_PLAY);
    check("play_fight_enable", 32'(fight_enable), 32'd1);
    check("play_busy", 32'(busy), 32'd1);
    pulse_start();
    probe("start_in_play_ignored", S_PLAY);

    pulse_ko();
    step(1);
    check("ko_fight_enable", 32'(fight_enable), 32'd0);
    probe("ko_entered", S_KO);
    d0 = done_cnt;
    ticks(179);
    probe("ko_at_179", S_KO);
    check("no_early_done", 32'(done_cnt), 32'(d0));
    ticks(1);
    check("done_one_pulse", 32'(done_cnt), 32'(d0 + 1));
    check("done_low_after", 32'(done), 32'd0);
    check("idle_busy_after_ko", 32'(busy), 32'd0);
    step(5);
    check("done_still_one", 32'(done_cnt), 32'(d0 + 1));
    probe("idle_after_ko", S_IDLE);

    start = 1'b1;
    ko    = 1'b1;
    step(1);
    start = 1'b0;
    ko    = 1'b0;
    probe("start_beats_ko", S_CNT3);
    ticks(180);
    probe("fight_again", S_FIGHT);
    pulse_ko();
    probe("ko_from_fight", S_KO);
    ticks(10);

    draw_x = 10'd370;
    draw_y = 10'd220;
    step(2);
    check("ko_pix_before_rst", 32'(ovl_valid), 32'd1);
    d0 = done_cnt;
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("rst_mid_ko_valid", 32'(ovl_valid), 32'd0);
    check("rst_mid_ko_busy", 32'(busy), 32'd0);
    check("rst_mid_ko_done", 32'(done), 32'd0);
    step(1);
    check("rst_mid_ko_valid_next", 32'(ovl_valid), 32'd0);
    draw_x = 10'd0;
    draw_y = 10'd0;
    ticks(180);
    check("no_done_after_rst", 32'(done_cnt), 32'(d0));
    probe("idle_after_rst", S_IDLE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/round_overlay_sequencer.md
# round_overlay_sequencer

- Sequences the round-announcement and KO overlays: countdown "3", "2", "1", then "FIGHT" at round start, and "KO" when a round ends.
- Drives one shared overlay address bus into the five overlay ROMs and muxes their 2-bit palette outputs into one overlay pixel stream for the VGA color mapper.
- Gates player control via `fight_enable`.
- Sits between the game-state logic (start/KO events) and the color mapper, alongside the background ROM path.

## Interface
Parameters:
- `FRAMES_DIGIT`, 60: frames each countdown digit is shown.
- `FRAMES_FIGHT`, 60: frames the FIGHT banner is shown.
- `FRAMES_KO`, 180: frames the KO banner is shown.
- `OVL_X0`, 288: overlay left edge, in pixels.
- `OVL_Y0`, 208: overlay top edge, in pixels.
- `DIGIT_W` / `DIGIT_H`, 64 / 64: digit image size (4096 words).
- `BANNER_W` / `BANNER_H`, 100 / 50: banner image size (5000 words).

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clock` in 1: system/pixel clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse, begin round countdown.
- `ko` in 1: one-cycle pulse, a player's health reached zero.
- `frame_tick` in 1: one-cycle pulse per frame (vsync edge).
- `draw_x` in 10: current pixel column.
- `draw_y` in 10: current pixel row.
- `rom_addr` out 13: shared address to all overlay ROMs.
- `q_cd3`, `q_cd2`, `q_cd1` in 2 each: digit ROM outputs.
- `q_fight`, `q_ko` in 2 each: banner ROM outputs.
- `ovl_valid` out 1: overlay pixel is opaque.
- `ovl_color` out 2: overlay palette index.
- `fight_enable` out 1: players may move and attack.
- `busy` out 1: sequencer not in IDLE.
- `done` out 1: one-cycle pulse when the KO display ends.

## Operation
States:
- IDLE
- CNT3
- CNT2
- CNT1
- FIGHT
- PLAY
- KO

Transitions:
- IDLE + `start` → CNT3.
- CNT3 → CNT2 → CNT1 → FIGHT, each after `FRAMES_DIGIT` frame ticks.
- FIGHT → PLAY after `FRAMES_FIGHT` frame ticks.
- PLAY or FIGHT + `ko` → KO.
- KO → IDLE after `FRAMES_KO` frame ticks; `done` pulses on that transition.

Frame counter:
- 8-bit frame counter cleared on every state entry.
- Increments on `frame_tick`.
- The state advances on the tick that makes the count equal the limit.

Event handling outside the listed transitions:
- `start` outside IDLE: ignored.
- `ko` outside FIGHT/PLAY: ignored.
- `start` and `ko` in the same cycle in IDLE: start wins.
- `frame_tick` coincident with a state entry: not counted, so each state lasts exactly its limit of ticks.

Overlay selection:
- CNT3/2/1 select the corresponding digit ROM with the digit geometry.
- FIGHT and KO select their ROMs with the banner geometry.
- IDLE and PLAY select nothing: `ovl_valid` = 0.

Address generation:
- In-box test: `OVL_X0 <= draw_x < OVL_X0 + W` and `OVL_Y0 <= draw_y < OVL_Y0 + H`.
- Address = `(draw_y - OVL_Y0) * W + (draw_x - OVL_X0)`, computed unsigned and truncated to 13 bits.
- Out of box: `rom_addr` = 0 and the in-box flag is cleared.

Output:
- Palette index 0 is transparent: `ovl_valid` = `inbox_d2 && sel_d2 != NONE && q != 0`.
- `ovl_color` = the selected q.

Control outputs:
- `fight_enable` = 1 in FIGHT and PLAY only.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, counter 0, `rom_addr` 0, all pipeline flags 0, `ovl_valid` 0, `ovl_color` 0, `fight_enable` 0, `busy` 0, `done` 0.
- Pipeline, cycle t: `draw_x`/`draw_y` sampled.
- Pipeline, t+1: `rom_addr`, in-box flag and selection registered (stage 1).
- Pipeline, t+2: ROM q valid, since the ROMs are registered. Stage-2 copies of in-box and selection align with q; `ovl_valid`/`ovl_color` are combinational from stage 2 and q.
- Total pixel latency: 2 cycles. The color mapper delays background by the same amount.
- The selection travels with the pixel, so a state change mid-line never pairs one ROM's address with another ROM's q.
- `fight_enable` and `busy` are registered and change the cycle after the state transition.
- `done` asserts for exactly one cycle.
- Reset mid-operation returns to IDLE on the next edge regardless of state; pipeline flags clear in the same cycle.

## Structure
Package `overlay_pkg` contains:
- State enum `ovl_state_t`.
- ROM select enum `ovl_sel_t` (NONE, CD3, CD2, CD1, FIGHT, KO).
- Geometry constants.
- Palette-transparent index constant.

Sub-module `overlay_addr_gen`:
- Inputs: `draw_x`, `draw_y`, selection.
- Output: registered address plus in-box flag, i.e. stage 1.
- The FSM and output mux stay in the top.

## Test plan
- Reset held low with `start` = 1 → all outputs 0, state IDLE; after release, no transition without a fresh `start` pulse.
- `start` pulse, 60 ticks per digit → CNT3/CNT2/CNT1 each last exactly 60 ticks. FIGHT follows at tick 180 and PLAY at tick 240, with `fight_enable` rising at tick 180.
- In CNT3, `draw_x` = 290, `draw_y` = 210 → `rom_addr` = 130 one cycle later; with `q_cd3` = 2, `ovl_valid` = 1 and `ovl_color` = 2 two cycles after input. With `q_cd3` = 0, `ovl_valid` = 0. `draw_x` = 352 → out of box, `ovl_valid` = 0.
- In FIGHT, `draw_x` = 387, `draw_y` = 257 → `rom_addr` = 4999, read from `q_fight`.
- `ko` in CNT2 → ignored. `ko` in PLAY → KO for 180 ticks, then IDLE with a single-cycle `done`; `start` and `ko` together in IDLE → CNT3.
- Reset asserted mid-KO → IDLE next edge, no `done` pulse, `ovl_valid` = 0 the following cycle.
